// File: rtl/automata_ctrl_pkg.sv
// Shared types for the automaton stream controller.
// FSM encoding, report record layout and a small ARM helper.
package automata_ctrl_pkg;

  localparam int NUM_REPORTS_D = 4;
  localparam int OFFSET_W_D    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    FINISH
  } ctrl_state_e;

  typedef struct packed {
    logic [OFFSET_W_D-1:0]    offset;
    logic [NUM_REPORTS_D-1:0] vector;
  } rpt_rec_t;

  function automatic logic [3:0] arm_last(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/automata_rpt_fifo.sv
// Report record FIFO: synchronous, flushable, show-ahead head register.
// rdata/rvalid are registered so the consumer sees flop outputs.
module automata_rpt_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic                     rvalid,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_n;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != FULL) | pop_ok);
  assign rd_nxt  = rd_ptr + AW'(pop_ok);
  assign count_n = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign free    = FULL - count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= count_n;
      rvalid <= (count_n != '0);
      // a record written into the next head slot bypasses the array
      rdata  <= (push_ok && wr_ptr == rd_nxt) ? wdata : mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/automata_stream_ctrl.sv
// Sequences one automaton: arms it, feeds symbols, tags non-zero reports
// with the causing symbol offset and queues them for the monitor side.
module automata_stream_ctrl
  import automata_ctrl_pkg::*;
#(
  parameter int NUM_REPORTS = NUM_REPORTS_D,
  parameter int OFFSET_W    = OFFSET_W_D,
  parameter int FIFO_DEPTH  = 8,
  parameter int ARM_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic [7:0]             sym_data,
  input  logic                   sym_last,
  output logic                   am_reset,
  output logic                   am_run,
  output logic [7:0]             am_symbols,
  input  logic [NUM_REPORTS-1:0] am_reports,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [OFFSET_W-1:0]    rpt_offset,
  output logic [NUM_REPORTS-1:0] rpt_vector,
  output logic                   busy,
  output logic                   done,
  output logic                   offset_wrap
);

  localparam int RW = OFFSET_W + NUM_REPORTS;
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] ARM_LAST = arm_last(ARM_CYCLES);

  ctrl_state_e         state;
  logic [3:0]          arm_cnt;
  logic [OFFSET_W-1:0] offset;
  logic [OFFSET_W-1:0] tag_off;
  logic                tag_v;
  logic                kill;
  logic                accept;
  logic                push;
  logic [CW:0]         fifo_free;
  logic [RW-1:0]       rd_data;

  assign kill = abort & (state == ARM || state == RUN || state == DRAIN);

  // keep one slot free for the record of the symbol still in flight
  assign sym_ready  = (state == RUN) & ~abort
                    & (fifo_free >= (CW+1)'(2));
  assign accept     = sym_valid & sym_ready;
  assign am_run     = accept;
  assign am_symbols = sym_data;
  assign push       = tag_v & (|am_reports) & ~kill;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign rpt_offset = rd_data[RW-1 -: OFFSET_W];
  assign rpt_vector = rd_data[NUM_REPORTS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      am_reset    <= 1'b1;
      arm_cnt     <= '0;
      offset      <= '0;
      offset_wrap <= 1'b0;
      tag_v       <= 1'b0;
      tag_off     <= '0;
    end else begin
      tag_v <= accept;
      if (accept) begin
        tag_off <= offset;
        offset  <= offset + OFFSET_W'(1);
        if (&offset) offset_wrap <= 1'b1;
      end
      if (kill) begin
        state    <= IDLE;
        am_reset <= 1'b1;
        tag_v    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state       <= ARM;
            arm_cnt     <= '0;
            offset      <= '0;
            offset_wrap <= 1'b0;
          end
          ARM: if (arm_cnt == ARM_LAST) begin
            state    <= RUN;
            am_reset <= 1'b0;
          end else begin
            arm_cnt <= arm_cnt + 4'd1;
          end
          RUN: if (accept && sym_last) state <= DRAIN;
          DRAIN: state <= FINISH;
          FINISH: begin
            state    <= IDLE;
            am_reset <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  automata_rpt_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (kill),
    .push   (push),
    .wdata  ({tag_off, am_reports}),
    .pop    (rpt_ready),
    .rvalid (rpt_valid),
    .rdata  (rd_data),
    .free   (fifo_free)
  );

endmodule

// File: tb/tb_automata_stream_ctrl.sv
// Bench for automata_stream_ctrl: automaton stub, stream-level reference
// model with per-cycle compare, directed cases and random streams.
module tb_automata_stream_ctrl;

  localparam int NR    = 4;
  localparam int OW    = 4;
  localparam int DEPTH = 8;
  localparam int ARMC  = 2;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_FIN   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sym_valid = 1'b0;
  logic          sym_ready;
  logic [7:0]    sym_data = 8'h00;
  logic          sym_last = 1'b0;
  logic          am_reset;
  logic          am_run;
  logic [7:0]    am_symbols;
  logic [NR-1:0] am_reports;
  logic          rpt_valid;
  logic          rpt_ready = 1'b0;
  logic [OW-1:0] rpt_offset;
  logic [NR-1:0] rpt_vector;
  logic          busy;
  logic          done;
  logic          offset_wrap;

  automata_stream_ctrl #(
    .NUM_REPORTS (NR),
    .OFFSET_W    (OW),
    .FIFO_DEPTH  (DEPTH),
    .ARM_CYCLES  (ARMC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_data    (sym_data),
    .sym_last    (sym_last),
    .am_reset    (am_reset),
    .am_run      (am_run),
    .am_symbols  (am_symbols),
    .am_reports  (am_reports),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_offset  (rpt_offset),
    .rpt_vector  (rpt_vector),
    .busy        (busy),
    .done        (done),
    .offset_wrap (offset_wrap)
  );

  always #5 clk = ~clk;

  // automaton stub: report = low nibble of the last symbol it advanced on
  always @(posedge clk) begin
    if (am_reset) am_reports <= '0;
    else if (am_run) am_reports <= am_symbols[3:0];
  end

  typedef struct {
    int off;
    int vec;
    int vis;
  } mrec_t;

  mrec_t mq[$];
  int    ph = P_IDLE;
  int    arm_n = 0;
  int    moff = 0;
  bit    mwrap = 1'b0;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  bit    checking = 1'b0;
  bit    rand_rdy = 1'b0;
  int    acc_cnt = 0;
  int    done_cnt = 0;
  int    log_off[$];
  int    log_vec[$];
  logic [7:0] sdat [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 50)
        $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // compare DUT against the model, then advance the model one cycle
  always @(negedge clk) begin : mon
    int    vc;
    bit    rdy_e;
    bit    rv_e;
    mrec_t r;
    if (checking) begin
      vc = 0;
      foreach (mq[i]) if (mq[i].vis <= cyc) vc++;
      rdy_e = (ph == P_RUN) && !abort && (vc <= DEPTH - 2);
      rv_e  = (mq.size() > 0) && (mq[0].vis <= cyc);
      chk("sym_ready", int'(sym_ready), int'(rdy_e));
      chk("am_run", int'(am_run), int'(sym_valid && rdy_e));
      if (am_run) chk("am_symbols", int'(am_symbols), int'(sym_data));
      chk("busy", int'(busy), int'(ph != P_IDLE));
      chk("done", int'(done), int'(ph == P_FIN));
      if (ph <= P_RUN) chk("am_reset", int'(am_reset), int'(ph != P_RUN));
      chk("offset_wrap", int'(offset_wrap), int'(mwrap));
      chk("rpt_valid", int'(rpt_valid), int'(rv_e));
      if (rv_e) begin
        chk("rpt_offset", int'(rpt_offset), mq[0].off);
        chk("rpt_vector", int'(rpt_vector), mq[0].vec);
      end
      if (sym_valid && sym_ready) acc_cnt++;
      if (done) done_cnt++;
      if (rv_e && rpt_ready && rpt_valid) begin
        log_off.push_back(int'(rpt_offset));
        log_vec.push_back(int'(rpt_vector));
      end
      if (reset) begin
        ph = P_IDLE;
        mq.delete();
        moff = 0;
        mwrap = 1'b0;
      end else begin
        if (rv_e && rpt_ready) void'(mq.pop_front());
        if (rdy_e && sym_valid) begin
          if (sym_data[3:0] != 4'h0) begin
            r.off = moff;
            r.vec = int'(sym_data[3:0]);
            r.vis = cyc + 2;
            mq.push_back(r);
          end
          if (moff == (1 << OW) - 1) mwrap = 1'b1;
          moff = (moff + 1) % (1 << OW);
        end
        if (abort && ph >= P_ARM && ph <= P_DRAIN) begin
          ph = P_IDLE;
          mq.delete();
        end else begin
          case (ph)
            P_IDLE: if (start) begin
              ph = P_ARM;
              arm_n = ARMC;
              moff = 0;
              mwrap = 1'b0;
            end
            P_ARM: begin
              arm_n--;
              if (arm_n == 0) ph = P_RUN;
            end
            P_RUN: if (rdy_e && sym_valid && sym_last) ph = P_DRAIN;
            P_DRAIN: ph = P_FIN;
            P_FIN: ph = P_IDLE;
            default: ph = P_IDLE;
          endcase
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input int n, input int vprob, input int abort_at);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    while (i < n) begin
      if (guard > 3000) begin
        chk("stream_timeout", i, n);
        break;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        sym_valid = 1'b1;
        sym_data = sdat[i];
        sym_last = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        sym_valid = 1'b0;
        return;
      end
      sym_valid = ($urandom_range(99) < vprob);
      sym_data = sdat[i];
      sym_last = (i == n - 1);
      if (rand_rdy) rpt_ready = $urandom_range(1);
      @(negedge clk);
      acc = sym_valid && sym_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    sym_valid = 1'b0;
    sym_last = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 300) begin
      if (rand_rdy) rpt_ready = $urandom_range(1);
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", int'(k < 300), 1);
  endtask

  task automatic drain();
    rpt_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drained", int'(rpt_valid), 0);
  endtask

  initial begin
    int l0;
    int d0;
    int a0;
    int k;
    int n;
    int ab;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_am_reset", int'(am_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rpt_valid", int'(rpt_valid), 0);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;

    // T1: basic stream, two non-zero reports
    rpt_ready = 1'b1;
    sdat[0] = 8'h00; sdat[1] = 8'h05; sdat[2] = 8'h00; sdat[3] = 8'h03;
    l0 = log_off.size();
    d0 = done_cnt;
    pulse_start();
    send_stream(4, 100, -1);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("t1_nrec", log_off.size() - l0, 2);
    if (log_off.size() - l0 == 2) begin
      chk("t1_off0", log_off[l0], 1);
      chk("t1_vec0", log_vec[l0], 5);
      chk("t1_off1", log_off[l0+1], 3);
      chk("t1_vec1", log_vec[l0+1], 3);
    end
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_busy", int'(busy), 0);

    // T2: arm window length, no accept while arming
    pulse_start();
    sym_valid = 1'b1;
    sym_data = 8'h02;
    sym_last = 1'b1;
    @(negedge clk);
    k = 0;
    while (am_reset && k < 10) begin
      chk("t2_ready_low", int'(sym_ready), 0);
      k++;
      @(negedge clk);
    end
    chk("t2_arm_len", k, 2);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym_last = 1'b0;
    wait_idle();
    drain();

    // T3: back-pressure with FIFO_DEPTH=8
    rpt_ready = 1'b0;
    for (int i = 0; i < 10; i++) sdat[i] = 8'h01;
    l0 = log_off.size();
    a0 = acc_cnt;
    pulse_start();
    fork
      send_stream(10, 100, -1);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t3_acc_stall", acc_cnt - a0, 8);
        chk("t3_stalled", int'(sym_ready), 0);
        @(posedge clk); #1;
        rpt_ready = 1'b1;
      end
    join
    wait_idle();
    drain();
    chk("t3_nrec", log_off.size() - l0, 10);
    if (log_off.size() - l0 == 10)
      for (int i = 0; i < 10; i++) chk("t3_off", log_off[l0+i], i);

    // T4: abort after 3 symbols, then a clean restart
    rpt_ready = 1'b0;
    d0 = done_cnt;
    pulse_start();
    send_stream(8, 100, 3);
    @(negedge clk);
    chk("t4_busy", int'(busy), 0);
    chk("t4_rpt_valid", int'(rpt_valid), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt - d0, 0);
    rpt_ready = 1'b1;
    sdat[0] = 8'h07; sdat[1] = 8'h00; sdat[2] = 8'h09;
    l0 = log_off.size();
    pulse_start();
    send_stream(3, 100, -1);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("t4_nrec", log_off.size() - l0, 2);
    if (log_off.size() - l0 == 2) begin
      chk("t4_off0", log_off[l0], 0);
      chk("t4_vec0", log_vec[l0], 7);
      chk("t4_off1", log_off[l0+1], 2);
      chk("t4_vec1", log_vec[l0+1], 9);
    end

    // T5: offset wrap with a 4-bit counter
    for (int i = 0; i < 18; i++) sdat[i] = 8'h01;
    l0 = log_off.size();
    pulse_start();
    send_stream(18, 100, -1);
    wait_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_wrap", int'(offset_wrap), 1);
    chk("t5_nrec", log_off.size() - l0, 18);
    if (log_off.size() - l0 == 18)
      for (int i = 0; i < 18; i++) chk("t5_off", log_off[l0+i], i % 16);
    @(posedge clk); #1;

    // T6: start held during RUN, then reset mid-stream
    pulse_start();
    start = 1'b1;
    sym_valid = 1'b1;
    sym_data = 8'h06;
    sym_last = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_busy_run", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    sym_valid = 1'b0;
    @(negedge clk);
    chk("t6_am_reset", int'(am_reset), 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_rpt_valid", int'(rpt_valid), 0);
    chk("t6_sym_ready", int'(sym_ready), 0);
    chk("t6_wrap", int'(offset_wrap), 0);
    @(posedge clk); #1;

    // random streams with random valid, consumer stalls and aborts
    rand_rdy = 1'b1;
    for (int s = 0; s < 10; s++) begin
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) sdat[i] = 8'($urandom_range(255));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
      pulse_start();
      send_stream(n, 70, ab);
      wait_idle();
    end
    rand_rdy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
